pcecd_scsi_target: RTL

//  CD-ROM drive side of the PCE CD SCSI bus. Sits downstream of the CPU register block, which drives
//  SEL/ACK/RST and the initiator data byte. Runs the target phase sequencer:
//  BUS_FREE -> COMMAND -> [DATA_IN] -> STATUS -> MESSAGE_IN -> BUS_FREE.

---
 rtl/pcecd_pkg.sv | 32 +++
 rtl/pcecd_cmd_buf.sv | 52 +++++
 rtl/pcecd_scsi_target.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pcecd_pkg.sv
// Shared types and constants for the PCE CD SCSI target: bus phases, bus bit masks,
// SCSI status codes and the CDB length decode.
package pcecd_pkg;

  typedef enum logic [2:0] {
    BUS_FREE,
    COMMAND,
    DATA_IN,
    STATUS,
    MESSAGE_IN
  } phase_t;

  localparam logic [7:0] BSY_MASK = 8'h80;
  localparam logic [7:0] REQ_MASK = 8'h40;
  localparam logic [7:0] MSG_MASK = 8'h20;
  localparam logic [7:0] CD_MASK  = 8'h10;
  localparam logic [7:0] IO_MASK  = 8'h08;

  localparam logic [7:0] STS_GOOD            = 8'h00;
  localparam logic [7:0] STS_CHECK_CONDITION = 8'h02;

  // The opcode group in bits [7:5] fixes the CDB length; reserved groups fall back to 6.
  function automatic logic [3:0] cdb_len(input logic [7:0] opcode);
    case (opcode[7:5])
      3'd0:       cdb_len = 4'd6;
      3'd1, 3'd2: cdb_len = 4'd10;
      3'd5:       cdb_len = 4'd12;
      default:    cdb_len = 4'd6;
    endcase
  endfunction

endpackage

// File: rtl/pcecd_cmd_buf.sv
// Command descriptor capture: stores up to CMD_MAX bytes, decodes the CDB length from byte 0
// and holds cmd_valid until the drive controller takes the command.
module pcecd_cmd_buf
  import pcecd_pkg::*;
#(
  parameter int CMD_MAX = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 set_valid,
  input  logic                 cmd_ready,
  output logic                 have_byte,
  output logic                 full,
  output logic                 cmd_done,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_len,
  output logic [CMD_MAX*8-1:0] cmd_bytes
);

  localparam int POS_W = $clog2(CMD_MAX + 1);

  logic [POS_W-1:0] pos;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pos       <= '0;
      cmd_bytes <= '0;
      cmd_valid <= 1'b0;
      cmd_done  <= 1'b0;
    end else begin
      // ACKs beyond the buffer depth are dropped rather than wrapping over byte 0
      if (wr_en && (pos < POS_W'(CMD_MAX))) begin
        cmd_bytes[int'(pos)*8 +: 8] <= wr_data;
        pos                         <= pos + POS_W'(1);
      end
      if (set_valid) begin
        cmd_valid <= 1'b1;
        cmd_done  <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign have_byte = (pos != '0);
  assign cmd_len   = have_byte ? cdb_len(cmd_bytes[7:0]) : 4'd0;
  assign full      = (int'(pos) >= int'(cmd_len)) || (int'(pos) == CMD_MAX);

endmodule

// File: rtl/pcecd_scsi_target.sv
// PCE CD SCSI target phase sequencer (COMMAND / DATA_IN / STATUS / MESSAGE_IN).
// Optional interrupt pulses are built when PCECD_TARGET_IRQ_EN is defined.
module pcecd_scsi_target
  import pcecd_pkg::*;
#(
  parameter int CMD_MAX = 12,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scsi_sel,
  input  logic                 scsi_ack,
  input  logic                 scsi_rst,
  input  logic [7:0]           db_in,
  output logic                 bsy,
  output logic                 req,
  output logic                 msg,
  output logic                 cd,
  output logic                 io,
  output logic [7:0]           db_out,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [3:0]           cmd_len,
  output logic [CMD_MAX*8-1:0] cmd_bytes,
  input  logic                 din_valid,
  input  logic [7:0]           din_data,
  input  logic                 din_last,
  output logic                 din_ready,
  input  logic                 sts_valid,
  input  logic [7:0]           sts_byte,
  input  logic [7:0]           msg_byte,
  output logic                 sts_ready,
  output logic [CNT_W-1:0]     xfer_count,
  output logic                 irq_xfer_ready,
  output logic                 irq_xfer_done
);

  phase_t     state;
  logic       last_q;
  logic [7:0] msg_q;
  logic       have_byte, full, cmd_done;
  logic       cap, set_valid, msg_release, buf_clr;

  assign cap         = (state == COMMAND) && req && scsi_ack;
  assign set_valid   = (state == COMMAND) && !req && !scsi_ack && have_byte && !cmd_done && full;
  assign msg_release = (state == MESSAGE_IN) && !req && !scsi_ack;
  assign buf_clr     = scsi_rst || msg_release;

  pcecd_cmd_buf #(.CMD_MAX(CMD_MAX)) u_cmd_buf (
    .clk       (clk),
    .reset     (reset),
    .clr       (buf_clr),
    .wr_en     (cap),
    .wr_data   (db_in),
    .set_valid (set_valid),
    .cmd_ready (cmd_ready),
    .have_byte (have_byte),
    .full      (full),
    .cmd_done  (cmd_done),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_bytes (cmd_bytes)
  );

`ifdef PCECD_TARGET_IRQ_EN
  logic stall_seen;
`endif

  always_ff @(posedge clk) begin
    if (reset || scsi_rst) begin
      state      <= BUS_FREE;
      {bsy, req, msg, cd, io} <= 5'b0;
      db_out     <= 8'h00;
      din_ready  <= 1'b0;
      sts_ready  <= 1'b0;
      xfer_count <= '0;
      last_q     <= 1'b0;
      msg_q      <= 8'h00;
`ifdef PCECD_TARGET_IRQ_EN
      irq_xfer_ready <= 1'b0;
      irq_xfer_done  <= 1'b0;
      stall_seen     <= 1'b0;
`endif
    end else begin
      din_ready <= 1'b0;
      sts_ready <= 1'b0;
`ifdef PCECD_TARGET_IRQ_EN
      irq_xfer_ready <= 1'b0;
      irq_xfer_done  <= 1'b0;
`endif
      case (state)
        BUS_FREE: begin
          if (scsi_sel) begin
            state <= COMMAND;
            bsy   <= 1'b1;
            cd    <= 1'b1;
            req   <= 1'b1;
          end
        end
        COMMAND: begin
          if (req && scsi_ack) begin
            req <= 1'b0;
          end else if (!req && !scsi_ack && have_byte && !cmd_done) begin
            if (!full) req <= 1'b1;
          end else if (!req && cmd_done && !cmd_valid) begin
            // Data takes priority over a status-only completion
            if (din_valid) begin
              state <= DATA_IN;
              io    <= 1'b1;
              cd    <= 1'b0;
            end else if (sts_valid) begin
              state     <= STATUS;
              sts_ready <= 1'b1;
              msg_q     <= msg_byte;
              db_out    <= sts_byte;
              cd        <= 1'b1;
              io        <= 1'b1;
              req       <= 1'b1;
            end
          end
        end
        DATA_IN: begin
          if (req && scsi_ack) begin
            req        <= 1'b0;
            xfer_count <= xfer_count + CNT_W'(1);
          end else if (!req && !scsi_ack) begin
            if (din_valid && !last_q) begin
              db_out    <= din_data;
              din_ready <= 1'b1;
              req       <= 1'b1;
              last_q    <= din_last;
`ifdef PCECD_TARGET_IRQ_EN
              stall_seen <= 1'b0;
`endif
            end else if (sts_valid) begin
              state     <= STATUS;
              sts_ready <= 1'b1;
              msg_q     <= msg_byte;
              db_out    <= sts_byte;
              cd        <= 1'b1;
              req       <= 1'b1;
`ifdef PCECD_TARGET_IRQ_EN
              irq_xfer_done <= 1'b1;
`endif
            end
`ifdef PCECD_TARGET_IRQ_EN
            else if (!last_q && !stall_seen) begin
              irq_xfer_ready <= 1'b1;
              stall_seen     <= 1'b1;
            end
`endif
          end
        end
        STATUS: begin
          if (req && scsi_ack) begin
            req <= 1'b0;
          end else if (!req && !scsi_ack) begin
            state  <= MESSAGE_IN;
            db_out <= msg_q;
            msg    <= 1'b1;
            req    <= 1'b1;
          end
        end
        MESSAGE_IN: begin
          if (req && scsi_ack) begin
            req <= 1'b0;
          end else if (!req && !scsi_ack) begin
            state      <= BUS_FREE;
            {bsy, req, msg, cd, io} <= 5'b0;
            db_out     <= 8'h00;
            xfer_count <= '0;
            last_q     <= 1'b0;
`ifdef PCECD_TARGET_IRQ_EN
            stall_seen <= 1'b0;
`endif
          end
        end
        default: state <= BUS_FREE;
      endcase
    end
  end

`ifndef PCECD_TARGET_IRQ_EN
  assign irq_xfer_ready = 1'b0;
  assign irq_xfer_done  = 1'b0;
`endif

endmodule
